// File: rtl/ysyx_22041412_muldiv_pkg.sv
// Shared definitions for the RV64M multiply/divide unit.
// Holds the op encodings, the FSM state encoding, the default width and the operand signedness decode.
package ysyx_22041412_muldiv_pkg;

   localparam int ysyx_22041412_XLEN_DEFAULT = 64;

   localparam logic [2:0] ysyx_22041412_MD_MUL    = 3'b000;
   localparam logic [2:0] ysyx_22041412_MD_MULH   = 3'b001;
   localparam logic [2:0] ysyx_22041412_MD_MULHSU = 3'b010;
   localparam logic [2:0] ysyx_22041412_MD_MULHU  = 3'b011;
   localparam logic [2:0] ysyx_22041412_MD_DIV    = 3'b100;
   localparam logic [2:0] ysyx_22041412_MD_DIVU   = 3'b101;
   localparam logic [2:0] ysyx_22041412_MD_REM    = 3'b110;
   localparam logic [2:0] ysyx_22041412_MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // The only multiply with an unsigned src1 is mulhu; the divide ops are signed when func3[0] is clear.
   function automatic logic md_src1_signed(input logic [2:0] op);
      return op[2] ? !op[0] : (op[1:0] != 2'b11);
   endfunction

   function automatic logic md_src2_signed(input logic [2:0] op);
      return op[2] ? !op[0] : !op[1];
   endfunction

endpackage

// File: rtl/ysyx_22041412_div_step.sv
// One restoring division step.
// It shifts the next dividend bit into the partial remainder and subtracts the divisor when that fits.
module ysyx_22041412_div_step #(
   parameter int W = 64
) (
   input  logic [W:0]   rem_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W:0]   rem_out,
   output logic         q_bit
);

   logic [W+1:0] wide;

   always_comb begin
      wide    = {rem_in, bit_in};
      q_bit   = (wide >= {2'b00, divisor});
      rem_out = (W+1)'(q_bit ? (wide - {2'b00, divisor}) : wide);
   end

endmodule

// File: rtl/ysyx_22041412_muldiv.sv
// Iterative RV64M multiply/divide unit.
// Operands are converted to magnitudes at accept, run for N cycles in CALC, and get their sign back in FIX.
module ysyx_22041412_muldiv
   import ysyx_22041412_muldiv_pkg::*;
#(
   parameter int XLEN = ysyx_22041412_XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   md_state_e         state, state_next;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_r;
   logic              word_r, neg_r;
   logic [XLEN-1:0]   mag1, mag2;
   logic [2*XLEN-1:0] mcand, acc;
   logic [XLEN:0]     rem;

   logic              word_eff, s1, s2, neg_in, is_special, accept, last_iter;
   logic [2:0]        op_eff;
   logic [XLEN-1:0]   a, b, a_mag, b_mag, min_val, special_val, fix_val, qv, rv, sel;
   logic [2*XLEN-1:0] prod;
   logic [XLEN:0]     step_rem;
   logic              step_q;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
      return XLEN'($signed(x));
   endfunction

   // Accept-side decode: every word multiply runs as mulw, and divide special cases skip the iteration entirely.
   always_comb begin
      word_eff = word && (XLEN == 64);
      op_eff   = (word_eff && !op[2]) ? ysyx_22041412_MD_MUL : op;
      a        = src1;
      b        = src2;
      if (word_eff) begin
         a = md_src1_signed(op_eff) ? sext32(src1[31:0]) : XLEN'(src1[31:0]);
         b = md_src2_signed(op_eff) ? sext32(src2[31:0]) : XLEN'(src2[31:0]);
      end
      s1     = md_src1_signed(op_eff) && a[XLEN-1];
      s2     = md_src2_signed(op_eff) && b[XLEN-1];
      a_mag  = s1 ? -a : a;
      b_mag  = s2 ? -b : b;
      neg_in = (op_eff == ysyx_22041412_MD_MULHSU || op_eff[2:1] == 2'b11) ? s1 : (s1 ^ s2);
      min_val     = word_eff ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
      is_special  = 1'b0;
      special_val = '0;
      if (op_eff[2]) begin
         if (b == '0) begin
            is_special  = 1'b1;
            special_val = op_eff[1] ? (word_eff ? sext32(src1[31:0]) : src1) : '1;
         end else if (!op_eff[0] && a == min_val && b == '1) begin
            is_special  = 1'b1;
            special_val = op_eff[1] ? '0 : a;
         end
      end
      accept    = (state == MD_IDLE) && in_valid && !flush;
      last_iter = (cnt == (word_r ? CW'(31) : CW'(XLEN-1)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_next;
   end

   // Flush beats both a new accept and a result handshake.
   always_comb begin
      state_next = state;
      case (state)
         MD_IDLE: if (accept) state_next = is_special ? MD_DONE : MD_CALC;
         MD_CALC: if (flush) state_next = MD_IDLE;
                  else if (last_iter) state_next = MD_FIX;
         MD_FIX:  state_next = flush ? MD_IDLE : MD_DONE;
         MD_DONE: if (flush || out_ready) state_next = MD_IDLE;
         default: state_next = MD_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == MD_IDLE);
   end

   ysyx_22041412_div_step #(.W(XLEN)) u_div_step (
      .rem_in  (rem),
      .bit_in  (mag1[XLEN-1]),
      .divisor (mag2),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_comb begin
      prod = neg_r ? -acc : acc;
      qv   = neg_r ? -mag1 : mag1;
      rv   = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
      sel  = op_r[1] ? rv : qv;
      if (!op_r[2]) begin
         if (word_r)                           fix_val = sext32(prod[31:0]);
         else if (op_r == ysyx_22041412_MD_MUL) fix_val = prod[XLEN-1:0];
         else                                  fix_val = prod[2*XLEN-1:XLEN];
      end else begin
         fix_val = word_r ? sext32(sel[31:0]) : sel;
      end
   end

   // Word dividends are left-aligned so the divider always consumes from the top bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         op_r      <= '0;
         word_r    <= 1'b0;
         neg_r     <= 1'b0;
         mag1      <= '0;
         mag2      <= '0;
         mcand     <= '0;
         acc       <= '0;
         rem       <= '0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= (state_next == MD_DONE);
         case (state)
            MD_IDLE: if (accept) begin
               op_r   <= op_eff;
               word_r <= word_eff;
               neg_r  <= neg_in;
               cnt    <= '0;
               acc    <= '0;
               rem    <= '0;
               mag2   <= b_mag;
               mcand  <= {{XLEN{1'b0}}, b_mag};
               mag1   <= (word_eff && op_eff[2]) ? (a_mag << (XLEN-32)) : a_mag;
               if (is_special) result <= special_val;
            end
            MD_CALC: begin
               cnt <= cnt + 1'b1;
               if (op_r[2]) begin
                  rem  <= step_rem;
                  mag1 <= {mag1[XLEN-2:0], step_q};
               end else begin
                  if (mag1[0]) acc <= acc + mcand;
                  mcand <= mcand << 1;
                  mag1  <= mag1 >> 1;
               end
            end
            MD_FIX: if (state_next == MD_DONE) result <= fix_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041412_muldiv.sv
// Directed bench for the multiply/divide unit at XLEN=64.
// Each step carries a hand-computed result and latency.
module tb_ysyx_22041412_muldiv;
   import ysyx_22041412_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, word, flush, out_valid, out_ready;
   logic [2:0]  op;
   logic [63:0] src1, src2, result;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   ysyx_22041412_muldiv #(.XLEN(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .word      (word),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   // Runs one operation, scrambles the inputs after accept, optionally stalls the consumer, then takes the result.
   task automatic apply_stimulus(input string tag, input logic [2:0] op_i, input logic word_i,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] exp_result, input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      check_output({tag, " in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      op       = op_i;
      word     = word_i;
      src1     = a;
      src2     = b;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         if (lat == 0) begin
            in_valid = 1'b0;
            src1     = ~a;
            src2     = ~b;
            op       = ~op_i;
         end
         lat++;
      end while (!out_valid && lat < 200);
      check_output({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_output({tag, " result"}, result, exp_result);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_output({tag, " hold valid"}, 64'(out_valid), 64'd1);
         check_output({tag, " hold result"}, result, exp_result);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_output({tag, " drained valid"}, 64'(out_valid), 64'd0);
      check_output({tag, " drained ready"}, 64'(in_ready), 64'd1);
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_output(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      op        = 3'b000;
      word      = 1'b0;
      src1      = '0;
      src2      = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #12;
      check_output("reset in_ready", 64'(in_ready), 64'd1);
      check_output("reset out_valid", 64'(out_valid), 64'd0);
      check_output("reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      apply_stimulus("mul 7*-3", ysyx_22041412_MD_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                     64'hFFFF_FFFF_FFFF_FFEB, 66, 10);
      apply_stimulus("mulhu max*max", ysyx_22041412_MD_MULHU, 1'b0, '1, '1,
                     64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
      apply_stimulus("mulh -1*-1", ysyx_22041412_MD_MULH, 1'b0, '1, '1, 64'd0, 66, 0);
      apply_stimulus("mulhsu -1*2", ysyx_22041412_MD_MULHSU, 1'b0, '1, 64'd2, '1, 66, 0);
      apply_stimulus("divu 100/0", ysyx_22041412_MD_DIVU, 1'b0, 64'd100, 64'd0, '1, 1, 0);
      apply_stimulus("remu 100/0", ysyx_22041412_MD_REMU, 1'b0, 64'd100, 64'd0, 64'd100, 1, 0);
      apply_stimulus("div ovf", ysyx_22041412_MD_DIV, 1'b0, 64'h8000_0000_0000_0000, '1,
                     64'h8000_0000_0000_0000, 1, 0);
      apply_stimulus("rem ovf", ysyx_22041412_MD_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
      apply_stimulus("divw ovf", ysyx_22041412_MD_DIV, 1'b1, 64'h0000_0000_8000_0000, '1,
                     64'hFFFF_FFFF_8000_0000, 1, 0);
      apply_stimulus("divw -7/2", ysyx_22041412_MD_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
      apply_stimulus("remw -7/2", ysyx_22041412_MD_REM, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, '1, 34, 0);
      apply_stimulus("div -7/2", ysyx_22041412_MD_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
      apply_stimulus("rem -7/2", ysyx_22041412_MD_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 66, 0);
      apply_stimulus("divu max/3", ysyx_22041412_MD_DIVU, 1'b0, '1, 64'd3, 64'h5555_5555_5555_5555, 66, 0);
      apply_stimulus("divu 100/7", ysyx_22041412_MD_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0);
      apply_stimulus("remu 100/7", ysyx_22041412_MD_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 66, 0);
      apply_stimulus("mulhu.w as mulw", ysyx_22041412_MD_MULHU, 1'b1, 64'h0000_0000_4000_0000, 64'd2,
                     64'hFFFF_FFFF_8000_0000, 34, 0);

      // Flush in the twentieth CALC cycle drops the operation.
      @(negedge clk);
      in_valid = 1'b1; op = ysyx_22041412_MD_MUL; word = 1'b0; src1 = 64'd5; src2 = 64'd6;
      @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_output("calc flush in_ready", 64'(in_ready), 64'd1);
      check_output("calc flush out_valid", 64'(out_valid), 64'd0);
      watch_quiet("calc flush no result", 80);

      // Flush alongside in_valid means no accept.
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; op = ysyx_22041412_MD_DIVU; src1 = 64'd9; src2 = 64'd0;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check_output("idle flush in_ready", 64'(in_ready), 64'd1);
      watch_quiet("idle flush no result", 10);

      // Flush in DONE wins over out_ready.
      @(negedge clk);
      in_valid = 1'b1; op = ysyx_22041412_MD_DIVU; src1 = 64'd9; src2 = 64'd0;
      @(negedge clk);
      in_valid = 1'b0;
      check_output("done before flush valid", 64'(out_valid), 64'd1);
      flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; out_ready = 1'b0;
      check_output("done flush out_valid", 64'(out_valid), 64'd0);
      check_output("done flush in_ready", 64'(in_ready), 64'd1);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      in_valid = 1'b1; op = ysyx_22041412_MD_MUL; word = 1'b0; src1 = 64'd3; src2 = 64'd4;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      check_output("mid reset in_ready", 64'(in_ready), 64'd1);
      check_output("mid reset out_valid", 64'(out_valid), 64'd0);
      check_output("mid reset result", result, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      watch_quiet("mid reset no result", 80);

      apply_stimulus("mul after reset", ysyx_22041412_MD_MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
                     64'hFFFF_FFFF_FFFF_FFEB, 66, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_22041412_muldiv.md
# ysyx_22041412_muldiv

Parametrised, iterative multiply/divide unit for RV64M. It sits beside the combinational integer ALU in the execute stage and is used for every M-extension opcode (func3 000–111, with or without the W suffix). It accepts one operation at a time over a valid/ready handshake and returns a registered result over a second valid/ready handshake. A pipeline flush can abort it at any point.

## Interface
Parameters:
- `XLEN`, default 64: datapath width. Legal values are 32 and 64; word ops exist only when XLEN=64.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the unit can accept; equal to state==IDLE.
- `op` in 3: M-ext func3. 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `word` in 1: selects the RV64 W variant (mulw/divw/divuw/remw/remuw).
- `src1`, `src2` in XLEN: the operands.
- `flush` in 1: abort the in-flight operation, synchronous.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: the consumer takes the result.
- `result` out XLEN: the registered result.

## Operation
- The FSM has four states:
  - IDLE: accepts when `in_valid`.
  - CALC: N iterations.
  - FIX: sign correction and result select.
  - DONE: holds the result until it is consumed.
- N = 32 when `word`=1, else XLEN. For word ops, operands are the low 32 bits: sign-extended for signed ops, zero-extended for unsigned ops.
- Signed operands are converted to magnitudes at accept. Result sign is applied in FIX:
  - quotient sign = sign1 XOR sign2;
  - remainder sign = sign1;
  - product sign = sign1 XOR sign2 for mul/mulh, and sign1 for mulhsu.
- Multiply is shift-add, one bit per cycle, into a 2N-bit accumulator.
  - mul returns the low N bits.
  - mulh, mulhsu and mulhu return the high N bits.
- Divide is restoring, one quotient bit per cycle, with an (N+1)-bit partial remainder.
- `word`=1 with op 001/010/011 is executed as mulw.
- Every word result is the 32-bit value sign-extended to 64 bits.
- Special cases bypass CALC and FIX (IDLE→DONE):
  - Divide by zero: div/divu give all ones; rem/remu give the dividend (for W variants, the sign-extended 32-bit dividend).
  - Signed overflow (most-negative ÷ −1): div gives the most-negative value and rem gives 0. For divw, most-negative means 0x8000_0000, sign-extended.
- Transitions:
  - IDLE→CALC on `in_valid`&&!`flush`.
  - CALC→FIX after iteration N.
  - FIX→DONE.
  - DONE→IDLE on `out_ready`.
  - `flush` forces IDLE from any state. It wins over a simultaneous accept and over a simultaneous `out_ready`, and no result is delivered.

## Timing
- Reset values: state IDLE, `out_valid`=0, `result`=0, iteration counter 0. `in_ready` reads 1 during and after reset.
- Accept happens on the rising edge where `in_valid`&&`in_ready`. Operands are captured into internal registers, so the inputs may change on the next cycle.
- Normal latency: `out_valid` rises N+2 cycles after the accept edge (N CALC + FIX + DONE entry). That is 66 cycles for XLEN=64 ops and 34 cycles for W ops.
- Special-case latency: `out_valid` rises 1 cycle after accept.
- `result` and `out_valid` stay stable while `out_valid`&&!`out_ready`, for any number of cycles.
- Throughput: at most one operation per N+3 cycles. `in_ready` reasserts the cycle after the handshake; there is no accept in DONE.
- `flush` takes effect at the next edge: `out_valid`=0 and `in_ready`=1 in the following cycle.
- Asserting `rst` mid-CALC returns to the reset values immediately. There is no output pulse afterwards.

## Structure
- The shared define file holds:
  - op encodings `ysyx_22041412_MD_*`;
  - FSM state encodings;
  - the default XLEN.
- Sub-module `ysyx_22041412_div_step`: one combinational restoring step, (N+1)-bit remainder in → remainder out plus quotient bit. It is instantiated once and reused every cycle.
- Multiply iteration, sign handling and special-case detection stay in the top module.

## Test plan
All scenarios use XLEN=64.
1. mul, 7 × −3 → 0xFFFF_FFFF_FFFF_FFEB. `out_valid` rises exactly 66 cycles after the accept edge.
2. mulhu, 0xFFFF_FFFF_FFFF_FFFF × itself → 0xFFFF_FFFF_FFFF_FFFE. mulh, −1 × −1 → 0.
3. Divide by zero: divu 100/0 → 0xFFFF_FFFF_FFFF_FFFF, and remu 100/0 → 100. `out_valid` rises 1 cycle after accept.
4. Overflow: div 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000, and rem → 0. divw 0x8000_0000 / −1 → 0xFFFF_FFFF_8000_0000.
5. W ops with src1=0x1234_5678_FFFF_FFF9 (low word −7), src2=2:
   - divw → 0xFFFF_FFFF_FFFF_FFFD;
   - remw → 0xFFFF_FFFF_FFFF_FFFF;
   - latency 34.
6. Control:
   - Hold `out_ready`=0 for 10 cycles: `result` stays stable.
   - Assert `flush` at CALC cycle 20: no `out_valid`, and `in_ready`=1 the next cycle.
   - Assert `rst` mid-CALC: all outputs go to reset values asynchronously.
